// File: rtl/sys_defs.sv
// Shared definitions for the memory responder: bus command encoding,
// tag width, and the completion-pipeline entry carried through the latency pipe.
package sys_defs;

  localparam int XLEN      = 32;
  localparam int MEM_TAG_W = 4;

  // LFSR seed used by the optional random-stall generator
  localparam logic [7:0] LFSR_SEED = 8'hA5;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'b00,
    BUS_LOAD  = 2'b01,
    BUS_STORE = 2'b10
  } bus_command_t;

  typedef struct packed {
    logic                 valid;
    logic [MEM_TAG_W-1:0] tag;
    logic [63:0]          data;
  } mem_resp_entry_t;

  // Tags run 1..15 and never issue 0, which means "no transaction"
  function automatic logic [MEM_TAG_W-1:0] tagAfter(input logic [MEM_TAG_W-1:0] t);
    return (t == 4'd15) ? 4'd1 : t + 4'd1;
  endfunction

endpackage

// File: rtl/mem_resp_pipe.sv
// Fixed-latency completion pipeline: an entry pushed at the accept edge
// emerges on o_entry exactly DEPTH cycles later. Reset (active low) flushes
// every stage so in-flight transactions are dropped.
module mem_resp_pipe
  import sys_defs::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  mem_resp_entry_t i_entry,
  output mem_resp_entry_t o_entry
);

  mem_resp_entry_t r_stage [DEPTH];

  // Shift every stage by one each cycle; the last stage drives the completion outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_entry;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_entry = r_stage[DEPTH-1];

endmodule

// File: rtl/mem_responder.sv
// Tagged memory responder with a fixed-latency completion path.
// Grants are combinational from the current command; loads capture memory at
// the accept edge, stores write at the accept edge and complete with zero data.
// Optional feature: define MEM_RANDOM_STALL_EN to add an 8-bit LFSR that forces
// refusals whenever its two low bits are zero.
// The reset input is asynchronous and active low; the backing store is not reset.
module mem_responder
  import sys_defs::*;
#(
  parameter int MEM_LATENCY = 4,
  parameter int MEM_WORDS   = 8192
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      proc2mem_command,
  input  logic [XLEN-1:0] proc2mem_addr,
  input  logic [63:0]     proc2mem_data,
  output logic [3:0]      mem2proc_response,
  output logic [63:0]     mem2proc_data,
  output logic [3:0]      mem2proc_tag
);

  logic [63:0]          r_mem [MEM_WORDS];
  logic [MEM_TAG_W-1:0] r_nextTag;
  logic [15:0]          r_busy;

  bus_command_t    w_cmd;
  logic [12:0]     w_wordIdx;
  logic            w_inRange;
  logic            w_stall;
  logic            w_accept;
  logic [15:0]     w_setMask;
  logic [15:0]     w_freeMask;
  mem_resp_entry_t w_pipeIn;
  mem_resp_entry_t w_pipeOut;
  logic            w_unusedAddrBits;

  assign w_cmd            = bus_command_t'(proc2mem_command);
  assign w_wordIdx        = proc2mem_addr[15:3];
  assign w_unusedAddrBits = ^proc2mem_addr[2:0];

`ifdef MEM_RANDOM_STALL_EN
  logic [7:0] r_lfsr;

  // Fibonacci LFSR for x^8+x^6+x^5+x^4+1, stepping every cycle out of reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
  assign w_stall = 1'b0;
`endif

  // Accept decision and the entry pushed into the latency pipe this cycle
  always_comb begin
    w_inRange = (proc2mem_addr[XLEN-1:16] == '0) && (32'(w_wordIdx) < MEM_WORDS);
    w_accept  = reset && ((w_cmd == BUS_LOAD) || (w_cmd == BUS_STORE)) &&
                w_inRange && !r_busy[r_nextTag] && !w_stall;
    w_pipeIn       = '0;
    w_pipeIn.valid = w_accept;
    if (w_accept) begin
      w_pipeIn.tag = r_nextTag;
      if (w_cmd == BUS_LOAD) begin
        w_pipeIn.data = r_mem[w_wordIdx];
      end
    end
    w_setMask  = w_accept ? (16'd1 << r_nextTag) : 16'd0;
    w_freeMask = w_pipeOut.valid ? (16'd1 << w_pipeOut.tag) : 16'd0;
  end

  // Tag allocator: mark granted tags busy, free a tag on the edge after it completes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy    <= '0;
      r_nextTag <= 4'd1;
    end else begin
      r_busy <= (r_busy & ~w_freeMask) | w_setMask;
      if (w_accept) begin
        r_nextTag <= tagAfter(r_nextTag);
      end
    end
  end

  // Backing store write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (w_accept && (w_cmd == BUS_STORE)) begin
      r_mem[w_wordIdx] <= proc2mem_data;
    end
  end

  mem_resp_pipe #(
    .DEPTH (MEM_LATENCY)
  ) u_pipe (
    .clk     (clk),
    .reset   (reset),
    .i_entry (w_pipeIn),
    .o_entry (w_pipeOut)
  );

  assign mem2proc_response = w_accept ? r_nextTag : 4'd0;
  assign mem2proc_tag      = w_pipeOut.tag;
  assign mem2proc_data     = w_pipeOut.data;

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: a latency-4 instance checked every cycle against
// a transaction-level reference model, and a latency-15 instance used for tag
// exhaustion. Honours MEM_RANDOM_STALL_EN when it is defined.
module tb_mem_responder;
  import sys_defs::*;

  localparam int LAT       = 4;
  localparam int LAT_LONG  = 15;
  localparam int WORDS     = 8192;
  localparam int PRE_WORDS = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  cmdA, cmdB;
  logic [31:0] addrA, addrB;
  logic [63:0] dataA, dataB;
  logic [3:0]  respA, respB, tagA, tagB;
  logic [63:0] rdataA, rdataB;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mem_responder #(.MEM_LATENCY(LAT), .MEM_WORDS(WORDS)) u_dut4 (
    .clk(clk), .reset(reset),
    .proc2mem_command(cmdA), .proc2mem_addr(addrA), .proc2mem_data(dataA),
    .mem2proc_response(respA), .mem2proc_data(rdataA), .mem2proc_tag(tagA)
  );

  mem_responder #(.MEM_LATENCY(LAT_LONG), .MEM_WORDS(WORDS)) u_dut15 (
    .clk(clk), .reset(reset),
    .proc2mem_command(cmdB), .proc2mem_addr(addrB), .proc2mem_data(dataB),
    .mem2proc_response(respB), .mem2proc_data(rdataB), .mem2proc_tag(tagB)
  );

  // Reference model: memory image, busy tags, next tag and a queue of
  // pending completions each stamped with the cycle it is due
  typedef struct {
    int          due;
    int          tag;
    logic [63:0] data;
  } pend_t;

  logic [63:0] mMem [PRE_WORDS];
  logic [63:0] preData [PRE_WORDS];
  bit          mBusy [16];
  int          mNextTag;
  pend_t       mQueue [$];
  int          cycleNo = 0;
`ifdef MEM_RANDOM_STALL_EN
  logic [7:0]  mLfsr;
`endif

  int          expResp, expTag;
  logic [63:0] expData;
  bit          expAccept, expPop;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic modelReset();
    mQueue.delete();
    for (int i = 0; i < 16; i++) mBusy[i] = 1'b0;
    mNextTag = 1;
`ifdef MEM_RANDOM_STALL_EN
    mLfsr = 8'hA5;
`endif
  endtask

  task automatic applyStimulus(input logic [1:0] c, input logic [31:0] a, input logic [63:0] d);
    bit stall;
    bit inRange;
    cmdA  = c;
    addrA = a;
    dataA = d;
    expPop  = (mQueue.size() > 0) && (mQueue[0].due == cycleNo);
    expTag  = expPop ? mQueue[0].tag  : 0;
    expData = expPop ? mQueue[0].data : 64'd0;
    inRange = (a[31:16] == 16'd0) && (int'(a[15:3]) < WORDS);
`ifdef MEM_RANDOM_STALL_EN
    stall = (mLfsr[1:0] == 2'b00);
`else
    stall = 1'b0;
`endif
    expAccept = ((c == 2'd1) || (c == 2'd2)) && inRange && !mBusy[mNextTag] && !stall;
    expResp   = expAccept ? mNextTag : 0;
  endtask

  task automatic checkOutput(input string name);
    check($sformatf("%s_resp", name), 64'(respA), 64'(expResp));
    check($sformatf("%s_tag", name),  64'(tagA),  64'(expTag));
    check($sformatf("%s_data", name), rdataA, expData);
  endtask

  task automatic endCycle();
    @(posedge clk);
    if (expPop) begin
      mBusy[mQueue[0].tag] = 1'b0;
      void'(mQueue.pop_front());
    end
    if (expAccept) begin
      mBusy[mNextTag] = 1'b1;
      if (cmdA == 2'd2) begin
        mMem[addrA[7:3]] = dataA;
        mQueue.push_back('{due: cycleNo + LAT, tag: mNextTag, data: 64'd0});
      end else begin
        mQueue.push_back('{due: cycleNo + LAT, tag: mNextTag, data: mMem[addrA[7:3]]});
      end
      mNextTag = (mNextTag == 15) ? 1 : mNextTag + 1;
    end
`ifdef MEM_RANDOM_STALL_EN
    mLfsr = {mLfsr[6:0], mLfsr[7] ^ mLfsr[5] ^ mLfsr[4] ^ mLfsr[3]};
`endif
    cycleNo++;
    #1;
  endtask

  task automatic stepCycle(input string name, input logic [1:0] c, input logic [31:0] a, input logic [63:0] d);
    applyStimulus(c, a, d);
    @(negedge clk);
    checkOutput(name);
    endCycle();
  endtask

  task automatic checkZeros(input string name);
    check($sformatf("%s_respA", name), 64'(respA), 64'd0);
    check($sformatf("%s_tagA", name),  64'(tagA),  64'd0);
    check($sformatf("%s_dataA", name), rdataA,     64'd0);
    check($sformatf("%s_respB", name), 64'(respB), 64'd0);
    check($sformatf("%s_tagB", name),  64'(tagB),  64'd0);
    check($sformatf("%s_dataB", name), rdataB,     64'd0);
  endtask

  task automatic doReset(input int n);
    reset = 1'b0;
    cmdA  = 2'd1; addrA = 32'h40;
    cmdB  = 2'd1; addrB = 32'h0;
    modelReset();
    #1;
    checkZeros("rst_async");
    repeat (n) begin
      @(negedge clk);
      checkZeros("rst_hold");
      @(posedge clk);
      #1;
    end
    cmdA  = 2'd0;
    cmdB  = 2'd0;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    cmdA = 2'd0; addrA = '0; dataA = '0;
    cmdB = 2'd0; addrB = '0; dataB = '0;
    #2;
    doReset(3);

    // Preload the low words so later loads return known data
    for (int w = 0; w < PRE_WORDS; w++) begin
      preData[w] = {$urandom, $urandom};
      stepCycle("preload", 2'd2, 32'(w) << 3, preData[w]);
    end
    repeat (LAT + 2) stepCycle("pre_drain", 2'd0, 32'h0, 64'd0);

    // Single load after reset; store contents must survive the reset
    doReset(2);
    applyStimulus(2'd1, 32'h0000_0040, 64'd0);
    @(negedge clk);
    checkOutput("r28_c0");
    check("r28_grant", 64'(respA), 64'd1);
    endCycle();
    for (int c = 1; c <= 5; c++) begin
      applyStimulus(2'd0, 32'h0, 64'd0);
      @(negedge clk);
      checkOutput($sformatf("r28_c%0d", c));
      if (c == 4) begin
        check("r28_tag4", 64'(tagA), 64'd1);
        check("r28_data4", rdataA, preData[8]);
      end else begin
        check($sformatf("r28_idle%0d", c), 64'(tagA), 64'd0);
      end
      endCycle();
    end

    // Store followed by a load of the same word on the next cycle
    doReset(2);
    applyStimulus(2'd2, 32'h10, 64'hDEAD_BEEF_0123_4567);
    @(negedge clk);
    checkOutput("r29_st");
    check("r29_grant_st", 64'(respA), 64'd1);
    endCycle();
    applyStimulus(2'd1, 32'h10, 64'd0);
    @(negedge clk);
    checkOutput("r29_ld");
    check("r29_grant_ld", 64'(respA), 64'd2);
    endCycle();
    for (int c = 2; c <= 6; c++) begin
      applyStimulus(2'd0, 32'h0, 64'd0);
      @(negedge clk);
      checkOutput($sformatf("r29_c%0d", c));
      if (c == 4) begin
        check("r29_tag_st", 64'(tagA), 64'd1);
        check("r29_data_st", rdataA, 64'd0);
      end
      if (c == 5) begin
        check("r29_tag_ld", 64'(tagA), 64'd2);
        check("r29_data_ld", rdataA, 64'hDEAD_BEEF_0123_4567);
      end
      endCycle();
    end

    // Out-of-range address is refused and never completes
    applyStimulus(2'd1, 32'h0001_0000, 64'd0);
    @(negedge clk);
    checkOutput("r31_req");
    check("r31_refused", 64'(respA), 64'd0);
    endCycle();
    repeat (LAT + 2) stepCycle("r31_wait", 2'd0, 32'h0, 64'd0);

    // Reset while three loads are in flight drops them; next grant is tag 1
    for (int k = 0; k < 3; k++) stepCycle("r32_ld", 2'd1, 32'(k) << 3, 64'd0);
    stepCycle("r32_gap", 2'd0, 32'h0, 64'd0);
    doReset(2);
    applyStimulus(2'd1, 32'h18, 64'd0);
    @(negedge clk);
    checkOutput("r32_after");
    check("r32_tag1", 64'(respA), 64'd1);
    endCycle();
    repeat (LAT + 3) stepCycle("r32_drain", 2'd0, 32'h0, 64'd0);

`ifndef MEM_RANDOM_STALL_EN
    // Tag exhaustion on the long-latency instance
    for (int k = 0; k <= 16; k++) begin
      cmdB  = 2'd1;
      addrB = 32'h0;
      applyStimulus(2'd0, 32'h0, 64'd0);
      @(negedge clk);
      checkOutput("r30_a");
      if (k < 15) begin
        check($sformatf("r30_resp%0d", k), 64'(respB), 64'(k + 1));
      end else if (k == 15) begin
        check("r30_refused", 64'(respB), 64'd0);
        check("r30_tag1_done", 64'(tagB), 64'd1);
      end else begin
        check("r30_regrant", 64'(respB), 64'd1);
      end
      if (k == 14) check("r30_tag_early", 64'(tagB), 64'd0);
      endCycle();
    end
    cmdB = 2'd0;
`else
    // Held load under random stall: model predicts each refusal
    doReset(2);
    for (int k = 0; k < 32; k++) stepCycle("r33_hold", 2'd1, 32'h28, 64'd0);
    repeat (LAT + 2) stepCycle("r33_drain", 2'd0, 32'h0, 64'd0);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      int          sel;
      logic [31:0] a;
      logic [1:0]  c;
      sel = int'($urandom_range(0, 9));
      a   = 32'($urandom_range(0, PRE_WORDS - 1)) << 3;
      a[2:0] = 3'($urandom_range(0, 7));
      if (sel <= 2) c = 2'd0;
      else if (sel <= 5) c = 2'd1;
      else if (sel <= 8) c = 2'd2;
      else begin
        c = 2'd1;
        a = a | (32'd1 << (16 + $urandom_range(0, 15)));
      end
      stepCycle("rand", c, a, {$urandom, $urandom});
    end
    repeat (LAT + 4) stepCycle("rand_drain", 2'd0, 32'h0, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter MEM_LATENCY, default 4: cycles from command acceptance to completion; legal range 1..15.
REQ-002 Parameter MEM_WORDS, default 8192: depth of backing store in 64-bit words (64 KB).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 proc2mem_command  input  2  BUS_NONE / BUS_LOAD / BUS_STORE.
REQ-006 proc2mem_addr  input  XLEN  byte address; bits [2:0] ignored.
REQ-007 proc2mem_data  input  64  store data.
REQ-008 mem2proc_response  output  4  tag granted this cycle; 0 = refused or no command.
REQ-009 mem2proc_data  output  64  completion data, valid when mem2proc_tag != 0.
REQ-010 mem2proc_tag  output  4  tag of transaction completing this cycle; 0 = none.

Function
REQ-011 mem2proc_response SHALL be combinational from the current command and state, so the requester samples the grant on the same edge it drives the command.
REQ-012 A command SHALL be accepted when command != BUS_NONE, proc2mem_addr[XLEN-1:16] == 0, word index < MEM_WORDS, and next_tag is not busy; otherwise response = 0 and no state changes.
REQ-013 Tags SHALL be 1..15; next_tag resets to 1, advances by one on each acceptance, and wraps 15 -> 1, never issuing 0.
REQ-014 An accepted tag SHALL be marked busy at the accept edge and freed at the edge after it appears on mem2proc_tag; a freed tag is grantable no earlier than the following cycle.
REQ-015 Load: memory[addr[15:3]] SHALL be captured at the accept edge and returned MEM_LATENCY cycles later with mem2proc_tag = granted tag, for exactly one cycle.
REQ-016 Store: memory[addr[15:3]] SHALL be written at the accept edge; completion SHALL appear MEM_LATENCY cycles later with mem2proc_data = 0.
REQ-017 A load accepted the cycle after a store to the same word SHALL return the stored data.
REQ-018 Completions SHALL be delivered in acceptance order through a MEM_LATENCY-deep shift pipeline, at most one per cycle; idle slots drive tag = 0, data = 0.
REQ-019 Acceptance and completion in the same cycle SHALL both occur without interference.
REQ-020 When all 15 tags are busy, every command SHALL be refused until a tag frees.

Reset
REQ-021 While reset is low: mem2proc_response = 0, mem2proc_tag = 0, mem2proc_data = 0, pipeline cleared, busy mask cleared, next_tag = 1.
REQ-022 Reset asserted with transactions in flight SHALL drop them silently; no completion for a pre-reset tag is ever emitted.
REQ-023 Backing store contents SHALL NOT be reset.

Configuration
REQ-024 Macro MEM_RANDOM_STALL_EN: when defined, an 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset, steps every cycle) SHALL force refusal whenever lfsr[1:0] == 2'b00, in addition to REQ-012.
REQ-025 Without MEM_RANDOM_STALL_EN, no LFSR exists and acceptance depends only on REQ-012.

Structure
REQ-026 BUS_NONE/BUS_LOAD/BUS_STORE encoding, MEM_TAG_W = 4, and the completion-pipeline entry struct {valid, tag, data} SHALL live in the shared sys_defs package.
REQ-027 The latency shift pipeline SHALL be a sub-module named mem_resp_pipe; tag allocation, storage and the LFSR stay in mem_responder.

Verification
REQ-028 Reset release, BUS_LOAD addr 0x0000_0040 at cycle 0 -> response = 1 same cycle; tag = 1 with memory[8] data at cycle 4; tag = 0 on cycles 1-3 and 5.
REQ-029 BUS_STORE addr 0x10, data 0xDEAD_BEEF_0123_4567, then BUS_LOAD addr 0x10 next cycle -> responses 1, 2; completions tag 1 data 0, then tag 2 data 0xDEAD_BEEF_0123_4567.
REQ-030 16 back-to-back loads with MEM_LATENCY = 15 -> responses 1..15, 16th refused (0); reissued 16th granted tag 1 only in the cycle after tag 1 completes.
REQ-031 BUS_LOAD addr 0x0001_0000 -> response 0, no completion ever appears.
REQ-032 Reset pulse while three loads are in flight -> all outputs 0 during reset, no stale tag afterwards; next accepted load receives tag 1.
REQ-033 MEM_RANDOM_STALL_EN defined, BUS_LOAD held 32 cycles -> refusals exactly on cycles where the reference LFSR model gives lfsr[1:0] == 0; every granted tag completes with correct data.
